// File: rtl/ll_pkg.sv
// ll_pkg: definitions shared by the linked-list response path.
//   - default widths for read-back data, node/size fields and list index
//   - t_resp_code   : codes carried on resp_code
//   - t_mngr_status : status values reported by the linked-list manager
//   - t_resp_gen_st : response generator states
//   - mngr_resp_code: maps a manager status to a response code
package ll_pkg;

   localparam int DATA_WIDTH    = 32;
   localparam int NODENUM_WIDTH = 8;
   localparam int NUM_LL_WIDTH  = 4;

   typedef enum logic [3:0] {
      RSP_OK            = 4'd0,
      RSP_NOP_ACK       = 4'd1,
      RSP_DECODE_ERR    = 4'd2,
      RSP_TIMEOUT       = 4'd3,
      RSP_MNGR_ERR_BASE = 4'd8
   } t_resp_code;

   // Values 4..7 are reserved/other and are passed through unchanged.
   typedef enum logic [2:0] {
      MST_OK          = 3'd0,
      MST_LL_EMPTY    = 3'd1,
      MST_POS_OOR     = 3'd2,
      MST_LL_INACTIVE = 3'd3
   } t_mngr_status;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_WAIT_MNGR = 2'd1,
      ST_HOLD_RESP = 2'd2,
      ST_CMPLT     = 2'd3
   } t_resp_gen_st;

   // A good status becomes RSP_OK; any other status keeps its value in the
   // low bits with bit 3 set, so the top sees which manager error occurred.
   function automatic logic [3:0] mngr_resp_code(input logic [2:0] status);
      logic [3:0] code;
      if (status == MST_OK) begin
         code = RSP_OK;
      end else begin
         code = RSP_MNGR_ERR_BASE | {1'b0, status};
      end
      return code;
   endfunction

endpackage

// File: rtl/ll_resp_timeout_ctr.sv
// ll_resp_timeout_ctr: cycle counter bounding the wait for the manager.
//   clk, reset_n : clock, synchronous active-low reset
//   clear        : return the count to zero (has priority over enable)
//   enable       : advance the count by one per cycle
//   expired      : count has reached TIMEOUT_CYCLES-1
// The count parks at its last value so expired stays asserted until cleared.
module ll_resp_timeout_ctr #(
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] count_r;

   // Cycle counter: cleared outside the wait, saturates at LAST.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         count_r <= '0;
      end else if (clear) begin
         count_r <= '0;
      end else if (enable && (count_r != LAST)) begin
         count_r <= count_r + 1'b1;
      end else begin
         count_r <= count_r;
      end
   end

   assign expired = (count_r == LAST);

endmodule

// File: rtl/ll_resp_gen_unit.sv
// ll_resp_gen_unit: turns one completion event per request into a single
// response beat on a valid/ready interface, then pulses resp_gen_cmpltd.
//   Inputs : resp_no_op, resp_gen_decode_err(+_type) from the decode unit;
//            req_taken, mngr_op_done, mngr_op_status/rd_data/ll_num/ll_size
//            from the linked-list manager; resp_rdy from top.
//   Outputs: resp_vld, resp_code, resp_data, resp_ll_num, resp_ll_size to top;
//            resp_gen_cmpltd to the decode unit; resp_count of accepted beats.
// All outputs come straight from registers.
module ll_resp_gen_unit #(
   parameter int DATA_WIDTH     = ll_pkg::DATA_WIDTH,
   parameter int NODENUM_WIDTH  = ll_pkg::NODENUM_WIDTH,
   parameter int NUM_LL_WIDTH   = ll_pkg::NUM_LL_WIDTH,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     resp_no_op,
   input  logic                     resp_gen_decode_err,
   input  logic                     resp_gen_decode_err_type,
   input  logic                     req_taken,
   input  logic                     mngr_op_done,
   input  logic [2:0]               mngr_op_status,
   input  logic [DATA_WIDTH-1:0]    mngr_rd_data,
   input  logic [NUM_LL_WIDTH-1:0]  mngr_ll_num,
   input  logic [NODENUM_WIDTH-1:0] mngr_ll_size,
   output logic                     resp_vld,
   input  logic                     resp_rdy,
   output logic [3:0]               resp_code,
   output logic [DATA_WIDTH-1:0]    resp_data,
   output logic [NUM_LL_WIDTH-1:0]  resp_ll_num,
   output logic [NODENUM_WIDTH-1:0] resp_ll_size,
   output logic                     resp_gen_cmpltd,
   output logic [15:0]              resp_count
);

   import ll_pkg::*;

   t_resp_gen_st             state_r;
   logic                     resp_vld_r;
   logic                     resp_gen_cmpltd_r;
   logic [3:0]               resp_code_r;
   logic [DATA_WIDTH-1:0]    resp_data_r;
   logic [NUM_LL_WIDTH-1:0]  resp_ll_num_r;
   logic [NODENUM_WIDTH-1:0] resp_ll_size_r;
   logic [15:0]              resp_count_r;
   logic                     timer_expired_s;
   logic                     timer_clear_s;
   logic                     timer_enable_s;

   // The timer only runs while waiting for the manager; entering the wait
   // from IDLE therefore always starts from zero.
   assign timer_clear_s  = (state_r != ST_WAIT_MNGR);
   assign timer_enable_s = (state_r == ST_WAIT_MNGR);

   ll_resp_timeout_ctr #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timeout_ctr (
      .clk     (clk),
      .reset_n (reset_n),
      .clear   (timer_clear_s),
      .enable  (timer_enable_s),
      .expired (timer_expired_s)
   );

   // Response FSM with its registered outputs and payload.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_r           <= ST_IDLE;
         resp_vld_r        <= 1'b0;
         resp_gen_cmpltd_r <= 1'b0;
         resp_code_r       <= 4'd0;
         resp_data_r       <= '0;
         resp_ll_num_r     <= '0;
         resp_ll_size_r    <= '0;
         resp_count_r      <= 16'd0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               resp_gen_cmpltd_r <= 1'b0;
               // Priority: decode error, then no-op, then manager request.
               if (resp_gen_decode_err) begin
                  resp_code_r    <= RSP_DECODE_ERR;
                  resp_data_r    <= {{(DATA_WIDTH-1){1'b0}}, resp_gen_decode_err_type};
                  resp_ll_num_r  <= '0;
                  resp_ll_size_r <= '0;
                  resp_vld_r     <= 1'b1;
                  state_r        <= ST_HOLD_RESP;
               end else if (resp_no_op) begin
                  resp_code_r    <= RSP_NOP_ACK;
                  resp_data_r    <= '0;
                  resp_ll_num_r  <= '0;
                  resp_ll_size_r <= '0;
                  resp_vld_r     <= 1'b1;
                  state_r        <= ST_HOLD_RESP;
               end else if (req_taken && mngr_op_done) begin
                  // Manager finished in the same cycle it took the request.
                  resp_code_r    <= mngr_resp_code(mngr_op_status);
                  resp_data_r    <= mngr_rd_data;
                  resp_ll_num_r  <= mngr_ll_num;
                  resp_ll_size_r <= mngr_ll_size;
                  resp_vld_r     <= 1'b1;
                  state_r        <= ST_HOLD_RESP;
               end else if (req_taken) begin
                  resp_vld_r <= 1'b0;
                  state_r    <= ST_WAIT_MNGR;
               end else begin
                  // A stray mngr_op_done without a request is dropped here.
                  resp_vld_r <= 1'b0;
                  state_r    <= ST_IDLE;
               end
            end

            ST_WAIT_MNGR: begin
               resp_gen_cmpltd_r <= 1'b0;
               // Done is checked first so it wins over a same-cycle expiry.
               if (mngr_op_done) begin
                  resp_code_r    <= mngr_resp_code(mngr_op_status);
                  resp_data_r    <= mngr_rd_data;
                  resp_ll_num_r  <= mngr_ll_num;
                  resp_ll_size_r <= mngr_ll_size;
                  resp_vld_r     <= 1'b1;
                  state_r        <= ST_HOLD_RESP;
               end else if (timer_expired_s) begin
                  resp_code_r    <= RSP_TIMEOUT;
                  resp_data_r    <= '0;
                  resp_ll_num_r  <= '0;
                  resp_ll_size_r <= '0;
                  resp_vld_r     <= 1'b1;
                  state_r        <= ST_HOLD_RESP;
               end else begin
                  resp_vld_r <= 1'b0;
                  state_r    <= ST_WAIT_MNGR;
               end
            end

            ST_HOLD_RESP: begin
               // resp_vld is high throughout this state; leave only on handshake.
               if (resp_rdy) begin
                  resp_vld_r        <= 1'b0;
                  resp_gen_cmpltd_r <= 1'b1;
                  resp_count_r      <= resp_count_r + 16'd1;
                  state_r           <= ST_CMPLT;
               end else begin
                  resp_vld_r        <= 1'b1;
                  resp_gen_cmpltd_r <= 1'b0;
                  state_r           <= ST_HOLD_RESP;
               end
            end

            ST_CMPLT: begin
               resp_vld_r        <= 1'b0;
               resp_gen_cmpltd_r <= 1'b0;
               state_r           <= ST_IDLE;
            end

            default: begin
               resp_vld_r        <= 1'b0;
               resp_gen_cmpltd_r <= 1'b0;
               state_r           <= ST_IDLE;
            end
         endcase
      end
   end

   assign resp_vld        = resp_vld_r;
   assign resp_gen_cmpltd = resp_gen_cmpltd_r;
   assign resp_code       = resp_code_r;
   assign resp_data       = resp_data_r;
   assign resp_ll_num     = resp_ll_num_r;
   assign resp_ll_size    = resp_ll_size_r;
   assign resp_count      = resp_count_r;

endmodule

// File: tb/tb_ll_resp_gen_unit.sv
// tb_ll_resp_gen_unit: scoreboard bench for ll_resp_gen_unit.
// The driver pushes the expected beat for every event it issues; a negedge
// monitor pops and compares on each handshake and also tracks the completion
// pulse, the accepted-response count and payload stability under backpressure.
module tb_ll_resp_gen_unit;

   localparam int DW = 32;
   localparam int NW = 8;
   localparam int LW = 4;
   localparam int TO = 16;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          resp_no_op;
   logic          resp_gen_decode_err;
   logic          resp_gen_decode_err_type;
   logic          req_taken;
   logic          mngr_op_done;
   logic [2:0]    mngr_op_status;
   logic [DW-1:0] mngr_rd_data;
   logic [LW-1:0] mngr_ll_num;
   logic [NW-1:0] mngr_ll_size;
   logic          resp_vld;
   logic          resp_rdy;
   logic [3:0]    resp_code;
   logic [DW-1:0] resp_data;
   logic [LW-1:0] resp_ll_num;
   logic [NW-1:0] resp_ll_size;
   logic          resp_gen_cmpltd;
   logic [15:0]   resp_count;

   always #5 clk = ~clk;

   ll_resp_gen_unit #(
      .DATA_WIDTH(DW), .NODENUM_WIDTH(NW), .NUM_LL_WIDTH(LW), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk), .reset_n(reset_n),
      .resp_no_op(resp_no_op),
      .resp_gen_decode_err(resp_gen_decode_err),
      .resp_gen_decode_err_type(resp_gen_decode_err_type),
      .req_taken(req_taken), .mngr_op_done(mngr_op_done),
      .mngr_op_status(mngr_op_status), .mngr_rd_data(mngr_rd_data),
      .mngr_ll_num(mngr_ll_num), .mngr_ll_size(mngr_ll_size),
      .resp_vld(resp_vld), .resp_rdy(resp_rdy),
      .resp_code(resp_code), .resp_data(resp_data),
      .resp_ll_num(resp_ll_num), .resp_ll_size(resp_ll_size),
      .resp_gen_cmpltd(resp_gen_cmpltd), .resp_count(resp_count)
   );

   typedef struct {
      logic [3:0]    code;
      logic [DW-1:0] data;
      logic [LW-1:0] ll;
      logic [NW-1:0] size;
   } exp_t;

   exp_t        exp_q[$];
   int          n_cmp = 0;
   int          n_fail = 0;
   logic [15:0] preload_val = 16'd0;
   int          preload_epoch = 0;

   // Event kinds used by the reference model.
   localparam int K_DEC = 0, K_NOP = 1, K_SAME = 2, K_WAIT = 3, K_TMO = 4;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
      end
   endtask

   // Response code from the event kind and manager status.
   function automatic logic [3:0] ref_code(input int kind, input int status);
      int c;
      case (kind)
         K_DEC:   c = 2;
         K_NOP:   c = 1;
         K_TMO:   c = 3;
         default: c = (status == 0) ? 0 : 8 + status;
      endcase
      return 4'(c);
   endfunction

   task automatic push_exp(input int kind, input logic [2:0] st, input logic [DW-1:0] d,
                           input logic [LW-1:0] ll, input logic [NW-1:0] sz, input logic et);
      exp_t e;
      e.code = ref_code(kind, int'(st));
      e.data = '0;
      e.ll   = '0;
      e.size = '0;
      if (kind == K_DEC) begin
         e.data = DW'(et);
      end else if (kind == K_SAME || kind == K_WAIT) begin
         e.data = d;
         e.ll   = ll;
         e.size = sz;
      end
      exp_q.push_back(e);
   endtask

   // ---------------- monitor ----------------
   logic [15:0]   exp_count = 16'd0;
   int            seen_epoch = 0;
   logic          pend_cmpltd = 1'b0;
   logic          prev_hold = 1'b0;
   logic [3:0]    prev_code;
   logic [DW-1:0] prev_data;
   logic [LW-1:0] prev_ll;
   logic [NW-1:0] prev_size;

   always @(negedge clk) begin
      exp_t e;
      if (seen_epoch != preload_epoch) begin
         seen_epoch = preload_epoch;
         exp_count  = preload_val;
      end
      check("cmpltd_pulse", 32'(resp_gen_cmpltd), 32'(pend_cmpltd));
      check("resp_count", 32'(resp_count), 32'(exp_count));
      if (prev_hold) begin
         check("vld_held", 32'(resp_vld), 32'd1);
         check("code_stable", 32'(resp_code), 32'(prev_code));
         check("data_stable", resp_data, prev_data);
         check("ll_stable", 32'(resp_ll_num), 32'(prev_ll));
         check("size_stable", 32'(resp_ll_size), 32'(prev_size));
      end
      if (!reset_n) begin
         pend_cmpltd = 1'b0;
         prev_hold   = 1'b0;
         exp_count   = 16'd0;
      end else begin
         pend_cmpltd = resp_vld && resp_rdy;
         if (resp_vld && resp_rdy) begin
            check("resp_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               check("resp_code", 32'(resp_code), 32'(e.code));
               check("resp_data", resp_data, e.data);
               check("resp_ll_num", 32'(resp_ll_num), 32'(e.ll));
               check("resp_ll_size", 32'(resp_ll_size), 32'(e.size));
            end
            exp_count = exp_count + 16'd1;
         end
         prev_hold = resp_vld && !resp_rdy;
         prev_code = resp_code;
         prev_data = resp_data;
         prev_ll   = resp_ll_num;
         prev_size = resp_ll_size;
      end
   end

   // ---------------- driver ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      resp_no_op = 1'b0; resp_gen_decode_err = 1'b0; req_taken = 1'b0; mngr_op_done = 1'b0;
   endtask

   task automatic wait_cmplt(input int rdy_low);
      bit got = 1'b0;
      if (rdy_low > 0) begin
         repeat (rdy_low) step();
         resp_rdy = 1'b1;
      end
      for (int i = 0; i < 8 && !got; i++) begin
         @(negedge clk);
         if (resp_gen_cmpltd) got = 1'b1;
      end
      check("cmpltd_seen", 32'(got), 32'd1);
      step();
      resp_rdy = 1'b0;
   endtask

   task automatic run_txn(input int kind, input int delay, input int rdy_low, input logic [2:0] st,
                          input logic [DW-1:0] d, input logic [LW-1:0] ll,
                          input logic [NW-1:0] sz, input logic et);
      resp_rdy = (rdy_low == 0);
      mngr_op_status = st; mngr_rd_data = d; mngr_ll_num = ll; mngr_ll_size = sz;
      resp_gen_decode_err_type = et;
      push_exp(kind, st, d, ll, sz, et);
      case (kind)
         K_DEC: begin
            resp_gen_decode_err = 1'b1;
            resp_no_op = 1'($urandom_range(0, 1));
            req_taken = 1'($urandom_range(0, 1));
            mngr_op_done = 1'($urandom_range(0, 1));
         end
         K_NOP: begin
            resp_no_op = 1'b1;
            req_taken = 1'($urandom_range(0, 1));
            mngr_op_done = 1'($urandom_range(0, 1));
         end
         K_SAME: begin
            req_taken = 1'b1;
            mngr_op_done = 1'b1;
         end
         default: begin
            req_taken = 1'b1;
            step();
            clear_inputs();
            // Other pulses during the wait must be ignored.
            repeat (((kind == K_TMO) ? TO : delay) - 1) begin
               resp_no_op = 1'($urandom_range(0, 3) == 0);
               resp_gen_decode_err = 1'($urandom_range(0, 3) == 0);
               req_taken = 1'($urandom_range(0, 3) == 0);
               step();
            end
            clear_inputs();
            if (kind == K_WAIT) mngr_op_done = 1'b1;
         end
      endcase
      @(negedge clk);
      check("no_early_vld", 32'(resp_vld), 32'd0);
      step();
      clear_inputs();
      @(negedge clk);
      check("capture_latency", 32'(resp_vld), 32'd1);
      wait_cmplt(rdy_low);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n = 1'b0; resp_rdy = 1'b0; resp_gen_decode_err_type = 1'b0;
      mngr_op_status = 3'd0; mngr_rd_data = '0; mngr_ll_num = '0; mngr_ll_size = '0;
      clear_inputs();
      repeat (3) step();
      @(negedge clk);
      check("rst_vld", 32'(resp_vld), 32'd0);
      check("rst_code", 32'(resp_code), 32'd0);
      check("rst_data", resp_data, 32'd0);
      check("rst_ll", 32'(resp_ll_num), 32'd0);
      check("rst_size", 32'(resp_ll_size), 32'd0);
      step();
      reset_n = 1'b1;
      repeat (2) step();

      // Directed cases.
      run_txn(K_DEC, 1, 0, 3'd0, 32'd0, 4'd0, 8'd0, 1'b1);
      run_txn(K_NOP, 1, 10, 3'd0, 32'd0, 4'd0, 8'd0, 1'b0);
      run_txn(K_WAIT, 7, 0, 3'd0, 32'hDEADBEEF, 4'd3, 8'd5, 1'b0);
      run_txn(K_SAME, 1, 0, 3'd2, 32'h1234_5678, 4'd9, 8'd17, 1'b0);
      run_txn(K_TMO, 1, 2, 3'd0, 32'h0, 4'd0, 8'd0, 1'b0);
      run_txn(K_WAIT, TO, 0, 3'd1, 32'hCAFE_F00D, 4'd15, 8'd255, 1'b0);
      run_txn(K_WAIT, 1, 1, 3'd7, 32'hFFFF_FFFF, 4'd1, 8'd1, 1'b0);

      // Randomized traffic.
      for (int i = 0; i < 120; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            mngr_op_done = 1'b1;
            step();
            mngr_op_done = 1'b0;
         end
         run_txn($urandom_range(0, 4), $urandom_range(1, TO),
                 ($urandom_range(0, 2) == 0) ? $urandom_range(1, 5) : 0,
                 3'($urandom), $urandom, 4'($urandom), 8'($urandom), 1'($urandom));
      end

      // Reset while holding a response: no beat and no completion follow.
      resp_rdy = 1'b0;
      resp_no_op = 1'b1;
      step();
      resp_no_op = 1'b0;
      @(negedge clk);
      check("hold_before_reset", 32'(resp_vld), 32'd1);
      step();
      reset_n = 1'b0;
      exp_q.delete();
      step();
      resp_rdy = 1'b1;
      @(negedge clk);
      check("mid_rst_vld", 32'(resp_vld), 32'd0);
      check("mid_rst_code", 32'(resp_code), 32'd0);
      check("mid_rst_data", resp_data, 32'd0);
      check("mid_rst_ll", 32'(resp_ll_num), 32'd0);
      check("mid_rst_size", 32'(resp_ll_size), 32'd0);
      step();
      reset_n = 1'b1;
      repeat (4) step();
      resp_rdy = 1'b0;

      // Counter wrap from 0xFFFF.
      force dut.resp_count_r = 16'hFFFF;
      preload_val = 16'hFFFF;
      preload_epoch++;
      step();
      release dut.resp_count_r;
      step();
      run_txn(K_NOP, 1, 0, 3'd0, 32'd0, 4'd0, 8'd0, 1'b0);
      @(negedge clk);
      check("count_wrap", 32'(resp_count), 32'd0);
      check("queue_drained", 32'(exp_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/ll_resp_gen_unit.md
Name: ll_resp_gen_unit

Overview:
Response generator downstream of the request decode unit and linked-list manager. It collects one completion event per request: a decode error, a no-op, a manager op-done, or a timeout. It formats that event into a single response beat on a valid/ready interface to top. When top accepts the beat, it pulses resp_gen_cmpltd so the decode unit returns to IDLE.

Parameters:
DATA_WIDTH, 32, width of read-back data returned by manager
NODENUM_WIDTH, 8, width of node position / list size fields
NUM_LL_WIDTH, 4, width of linked-list index
TIMEOUT_CYCLES, 1024, max cycles from req_taken to mngr_op_done before a TIMEOUT response; must be >=2

Ports:
clk  in  1  clock
reset_n  in  1  reset; synchronous, active-low
resp_no_op  in  1  pulse from decode unit: NO_OP request
resp_gen_decode_err  in  1  pulse from decode unit: bad specifier
resp_gen_decode_err_type  in  1  decode error subtype
req_taken  in  1  pulse: manager accepted forwarded request
mngr_op_done  in  1  pulse: manager finished operation
mngr_op_status  in  3  0=OK, 1=LL_EMPTY, 2=POS_OOR, 3=LL_INACTIVE, 4..7=reserved/other
mngr_rd_data  in  DATA_WIDTH  read-back data, valid with mngr_op_done
mngr_ll_num  in  NUM_LL_WIDTH  list index, valid with mngr_op_done
mngr_ll_size  in  NODENUM_WIDTH  list size after op, valid with mngr_op_done
resp_vld  out  1  response beat valid to top
resp_rdy  in  1  top ready
resp_code  out  4  t_resp_code
resp_data  out  DATA_WIDTH  response payload
resp_ll_num  out  NUM_LL_WIDTH  list index
resp_ll_size  out  NODENUM_WIDTH  list size
resp_gen_cmpltd  out  1  one-cycle pulse to decode unit
resp_count  out  16  accepted-response counter

Behaviour:
- Reset values: state IDLE; all outputs 0; payload registers, timer and resp_count cleared.
- Reset asserted mid-operation aborts everything. No response and no resp_gen_cmpltd are issued.
- States: IDLE, WAIT_MNGR, HOLD_RESP, CMPLT.
- IDLE, input priority decode_err > no_op > req_taken:
  - decode_err: capture code DECODE_ERR (2), resp_data = zero-extended err_type, ll_num/size = 0; go to HOLD_RESP.
  - no_op: capture NOP_ACK (1), payload 0; go to HOLD_RESP.
  - req_taken with mngr_op_done in the same cycle: capture the manager result; go to HOLD_RESP.
  - req_taken alone: clear timer; go to WAIT_MNGR.
  - mngr_op_done without req_taken: ignored.
- WAIT_MNGR: timer increments by 1 each cycle.
  - mngr_op_done: capture code, mngr_rd_data, mngr_ll_num, mngr_ll_size; go to HOLD_RESP.
  - Else if timer == TIMEOUT_CYCLES-1: capture TIMEOUT (3), payload 0; go to HOLD_RESP.
  - If done and timeout occur in the same cycle, done wins.
  - Other input pulses are ignored.
- Manager code mapping: status 0 gives OK (0); status s != 0 gives 4'h8 | s.
- HOLD_RESP: resp_vld=1, payload stable until handshake.
  - On resp_vld & resp_rdy: go to CMPLT; resp_count += 1, wrapping 0xFFFF -> 0.
  - resp_rdy low holds the state indefinitely; no timeout applies here.
- CMPLT: resp_gen_cmpltd=1 for exactly one cycle; resp_vld=0; go to IDLE.
- Latency:
  - Capturing event in cycle N gives resp_vld high in cycle N+1.
  - Handshake in cycle M gives resp_gen_cmpltd in M+1, back in IDLE at M+2.
- resp_vld, resp_gen_cmpltd and payload are registered outputs, so there is no combinational path from inputs to outputs.
- resp_vld never deasserts without a handshake.

Decomposition:
- Shared package ll_pkg:
  - t_resp_code enum {RSP_OK=0, RSP_NOP_ACK=1, RSP_DECODE_ERR=2, RSP_TIMEOUT=3, RSP_MNGR_ERR_BASE=8}
  - t_mngr_status enum
  - width constants DATA_WIDTH, NODENUM_WIDTH, NUM_LL_WIDTH
  - t_resp_gen_st state enum
- Sub-module ll_resp_timeout_ctr, with clear/enable inputs and an expired output at TIMEOUT_CYCLES-1.

Test Plan:
1. Decode error: resp_gen_decode_err=1, err_type=1 in cycle 5, resp_rdy=1 -> cycle 6 resp_vld=1, resp_code=2, resp_data=1; cycle 7 resp_gen_cmpltd=1; resp_count=1.
2. No-op with backpressure: resp_no_op pulse, resp_rdy low for 10 cycles -> resp_vld held with code 1 and stable payload for 10 cycles; single resp_gen_cmpltd after resp_rdy rises.
3. Normal op: req_taken, then 7 cycles later mngr_op_done with status 0, rd_data=0xDEADBEEF, ll_num=3, size=5 -> resp_code=0, resp_data=0xDEADBEEF, resp_ll_num=3, resp_ll_size=5.
4. Manager error and same-cycle done: req_taken+mngr_op_done together with status 2 -> next-cycle resp_code=0xA; no WAIT_MNGR visit.
5. Timeout boundary: TIMEOUT_CYCLES=16, req_taken with no done -> resp_code=3 exactly 16 cycles later. Rerun with done on the 16th cycle -> manager result returned, not TIMEOUT.
6. Reset in HOLD_RESP and counter wrap: reset_n low in HOLD_RESP -> all outputs 0, no cmpltd pulse. Preload resp_count to 0xFFFF, complete one response -> resp_count wraps to 0.
